// File: rtl/ppm16_rx_ctrl.sv
// ppm16_rx_ctrl - receive sequencer for the 16-PPM demodulator.
// Arms the demodulator, steps the correlation threshold down while the
// demodulator scans without finding a preamble, then packs received 4-bit
// symbols into bytes for the RX FIFO and flags the end of each packet.
// Optional feature: define PPM16_RX_CTRL_PKTCNT_EN to add a 16-bit packet
// counter whose low byte is written as the first FIFO byte of every packet.

module ppm16_rx_ctrl #(
    parameter int CHIP_BITS = 1,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [CHIP_BITS-1:0] thresh_init,
    input  logic [CHIP_BITS-1:0] thresh_min,
    input  logic [TIMEOUT_W-1:0] scan_timeout,
    input  logic [2:0]           demod_state,
    input  logic                 demod_packet_detected,
    input  logic                 demod_dout_valid,
    input  logic [3:0]           demod_dout,
    output logic                 demod_rx_start,
    output logic                 demod_clr_n,
    output logic [CHIP_BITS-1:0] demod_corr_threshold,
    output logic [7:0]           fifo_wdata,
    output logic                 fifo_wvalid,
    input  logic                 fifo_full,
    output logic                 pkt_done,
    output logic [7:0]           overflow_count,
    output logic [2:0]           ctrl_state
`ifdef PPM16_RX_CTRL_PKTCNT_EN
    ,
    output logic [15:0]          pkt_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_ARM     = 3'b001,
        S_SEARCH  = 3'b010,
        S_RECEIVE = 3'b011,
        S_DONE    = 3'b100
    } state_t;

    localparam logic [2:0] DEMOD_IDLE = 3'b000;
    localparam logic [2:0] DEMOD_SCAN = 3'b001;

    state_t                 r_state;
    state_t                 w_nextState;

    logic [CHIP_BITS-1:0]   r_thr;
    logic [CHIP_BITS-1:0]   w_nextThr;
    logic [CHIP_BITS-1:0]   w_thrStep;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic [TIMEOUT_W-1:0]   w_nextCnt;
    logic [TIMEOUT_W-1:0]   w_cntInc;
    logic                   w_timeoutHit;

    logic                   r_phase;
    logic                   w_nextPhase;
    logic [3:0]             r_hiNib;
    logic [3:0]             w_nextHiNib;

    logic [7:0]             r_wdata;
    logic [7:0]             w_nextWdata;
    logic                   r_wvalid;
    logic                   w_nextWvalid;
    logic                   w_writeReq;
    logic [7:0]             w_writeByte;
    logic [7:0]             r_ovf;
    logic [7:0]             w_nextOvf;

    logic                   r_rxStart;
    logic                   w_nextRxStart;
    logic                   r_clrN;
    logic                   w_nextClrN;
    logic                   r_pktDone;
    logic                   w_nextPktDone;

`ifdef PPM16_RX_CTRL_PKTCNT_EN
    logic [15:0]            r_pktCnt;
    logic [15:0]            w_nextPktCnt;
    logic                   r_hdrPend;
    logic                   w_nextHdrPend;
`endif

    // The scan counter advances by one; a step fires on the cycle it would
    // reach scan_timeout, so the threshold moves every scan_timeout cycles.
    assign w_cntInc     = r_cnt + TIMEOUT_W'(1);
    assign w_timeoutHit = (scan_timeout != '0) && (w_cntInc == scan_timeout);
    assign w_thrStep    = (r_thr > thresh_min) ? (r_thr - CHIP_BITS'(1)) : thresh_init;

    // State register of the sequencer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the next value of every registered output.
    always_comb begin
        w_nextState   = r_state;
        w_nextThr     = r_thr;
        w_nextCnt     = r_cnt;
        w_nextPhase   = r_phase;
        w_nextHiNib   = r_hiNib;
        w_nextWdata   = r_wdata;
        w_nextWvalid  = 1'b0;
        w_nextOvf     = r_ovf;
        w_nextRxStart = 1'b0;
        w_nextClrN    = 1'b1;
        w_nextPktDone = 1'b0;
        w_writeReq    = 1'b0;
        w_writeByte   = r_wdata;
`ifdef PPM16_RX_CTRL_PKTCNT_EN
        w_nextPktCnt  = r_pktCnt;
        w_nextHdrPend = r_hdrPend;
`endif

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_nextState = S_ARM;
                end
            end

            S_ARM: begin
                w_nextThr     = thresh_init;
                w_nextCnt     = '0;
                w_nextRxStart = 1'b1;
                w_nextState   = S_SEARCH;
            end

            S_SEARCH: begin
                if (demod_state == DEMOD_SCAN) begin
                    if (w_timeoutHit) begin
                        w_nextThr = w_thrStep;
                        w_nextCnt = '0;
                    end else begin
                        w_nextCnt = w_cntInc;
                    end
                end else begin
                    w_nextCnt = '0;
                end

                if (demod_packet_detected) begin
                    w_nextState = S_RECEIVE;
                    w_nextPhase = 1'b0;
`ifdef PPM16_RX_CTRL_PKTCNT_EN
                    w_nextHdrPend = 1'b1;
`endif
                end else if (!enable) begin
                    w_nextClrN  = 1'b0;
                    w_nextState = S_IDLE;
                end
            end

            S_RECEIVE: begin
`ifdef PPM16_RX_CTRL_PKTCNT_EN
                if (r_hdrPend) begin
                    w_writeReq    = 1'b1;
                    w_writeByte   = r_pktCnt[7:0];
                    w_nextHdrPend = 1'b0;
                end
`endif
                if (demod_dout_valid) begin
                    if (!r_phase) begin
                        w_nextHiNib = demod_dout;
                        w_nextPhase = 1'b1;
                    end else begin
                        w_writeReq  = 1'b1;
                        w_writeByte = {r_hiNib, demod_dout};
                        w_nextPhase = 1'b0;
                    end
                end
                if (demod_state == DEMOD_IDLE) begin
                    w_nextState = S_DONE;
                end
            end

            S_DONE: begin
                if (r_phase) begin
                    w_writeReq  = 1'b1;
                    w_writeByte = {r_hiNib, 4'h0};
                    w_nextPhase = 1'b0;
                end
                w_nextPktDone = 1'b1;
`ifdef PPM16_RX_CTRL_PKTCNT_EN
                w_nextPktCnt  = r_pktCnt + 16'd1;
`endif
                w_nextState   = enable ? S_ARM : S_IDLE;
            end

            default: begin
                w_nextState = S_IDLE;
            end
        endcase

        if (w_writeReq) begin
            if (fifo_full) begin
                if (r_ovf != 8'hFF) begin
                    w_nextOvf = r_ovf + 8'd1;
                end
            end else begin
                w_nextWvalid = 1'b1;
                w_nextWdata  = w_writeByte;
            end
        end
    end

    // Datapath and output registers; reset also discards any held nibble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_thr     <= '0;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            r_hiNib   <= 4'h0;
            r_wdata   <= 8'h00;
            r_wvalid  <= 1'b0;
            r_ovf     <= 8'h00;
            r_rxStart <= 1'b0;
            r_clrN    <= 1'b1;
            r_pktDone <= 1'b0;
        end else begin
            r_thr     <= w_nextThr;
            r_cnt     <= w_nextCnt;
            r_phase   <= w_nextPhase;
            r_hiNib   <= w_nextHiNib;
            r_wdata   <= w_nextWdata;
            r_wvalid  <= w_nextWvalid;
            r_ovf     <= w_nextOvf;
            r_rxStart <= w_nextRxStart;
            r_clrN    <= w_nextClrN;
            r_pktDone <= w_nextPktDone;
        end
    end

`ifdef PPM16_RX_CTRL_PKTCNT_EN
    // Packet counter and the pending packet-number header byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pktCnt  <= 16'h0000;
            r_hdrPend <= 1'b0;
        end else begin
            r_pktCnt  <= w_nextPktCnt;
            r_hdrPend <= w_nextHdrPend;
        end
    end

    assign pkt_count = r_pktCnt;
`endif

    assign demod_rx_start       = r_rxStart;
    assign demod_clr_n          = r_clrN;
    assign demod_corr_threshold = r_thr;
    assign fifo_wdata           = r_wdata;
    assign fifo_wvalid          = r_wvalid;
    assign pkt_done             = r_pktDone;
    assign overflow_count       = r_ovf;
    assign ctrl_state           = r_state;

endmodule
